// File: rtl/fp16_pkg.sv
// Shared constants and state encoding for the FP16 -> INT16 converter.
// The build option FP16_CVT_ROUND_EN selects round-to-nearest-even over truncation.
package fp16_pkg;
  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP16_BIAS  = 15;
  localparam logic [4:0]  FP16_EXP_MAX = 5'b11111;
  localparam logic [15:0] INT16_MAX = 16'h7FFF;
  localparam logic [15:0] INT16_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    DONE
  } cvt_state_t;
endpackage

// File: rtl/fp16_classify.sv
// Combinational FP16 field split and operand classification.
// Subnormals carry no implicit one.
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [15:0] x,
  output logic        sign,
  output logic [4:0]  exp,
  output logic [10:0] mant_with_implicit,
  output logic        is_zero,
  output logic        is_subnormal,
  output logic        is_inf,
  output logic        is_nan
);
  logic [FP16_MAN_W-1:0] frac;
  logic                  frac_nz;
  logic                  exp_max;

  assign sign    = x[15];
  assign exp     = x[14:10];
  assign frac    = x[9:0];
  assign frac_nz = |frac;
  assign exp_max = (exp == FP16_EXP_MAX);

  assign mant_with_implicit = {exp != 5'd0, frac};

  assign is_zero      = (exp == 5'd0) && !frac_nz;
  assign is_subnormal = (exp == 5'd0) && frac_nz;
  assign is_inf       = exp_max && !frac_nz;
  assign is_nan       = exp_max && frac_nz;
endmodule

// File: rtl/fp16_to_int16_converter.sv
// Iterative FP16 -> signed INT16 converter, one mantissa shift per cycle.
// Define FP16_CVT_ROUND_EN for round-to-nearest-even; default truncates.
module fp16_to_int16_converter
  import fp16_pkg::*;
#(
  parameter logic [15:0] NAN_VALUE = 16'h0000,
  parameter bit          SATURATE  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] r,
  output logic        invalid,
  output logic        inexact,
  output logic        busy
);
  logic        c_sign;
  logic [4:0]  c_exp;
  logic [10:0] c_mant;
  logic        c_zero;
  logic        c_sub;
  logic        c_inf;
  logic        c_nan;

  fp16_classify u_cls (
    .x                  (x),
    .sign               (c_sign),
    .exp                (c_exp),
    .mant_with_implicit (c_mant),
    .is_zero            (c_zero),
    .is_subnormal       (c_sub),
    .is_inf             (c_inf),
    .is_nan             (c_nan)
  );

  cvt_state_t  state;
  logic        sign_q;
  logic        left_q;
  logic        guard_q;
  logic        sticky_q;
  logic [3:0]  cnt_q;
  logic [15:0] mag_q;

  logic        is_min;
  logic        is_ovf;
  logic        left;
  logic [4:0]  rsh;
  logic [3:0]  n_init;
  logic [15:0] sat_val;
  logic        inc;
  logic [15:0] rnd_mag;

  // -32768 is the single e==30 value that still fits
  assign is_min  = (c_exp == 5'd30) && c_sign && (c_mant[9:0] == 10'd0);
  assign is_ovf  = (c_exp == 5'd30) && !is_min;
  assign left    = (c_exp >= 5'd25);
  assign rsh     = 5'd25 - c_exp;
  assign n_init  = left ? 4'(c_exp - 5'd25)
                 : (rsh > 5'd12) ? 4'd12 : rsh[3:0];
  assign sat_val = (SATURATE && !c_sign) ? INT16_MAX : INT16_MIN;

`ifdef FP16_CVT_ROUND_EN
  assign inc = guard_q & (sticky_q | mag_q[0]);
`else
  assign inc = 1'b0;
`endif
  assign rnd_mag = mag_q + {15'd0, inc};

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sign_q   <= 1'b0;
      left_q   <= 1'b0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= 4'd0;
      mag_q    <= 16'd0;
      r        <= 16'd0;
      invalid  <= 1'b0;
      inexact  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q   <= c_sign;
            left_q   <= left;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= n_init;
            mag_q    <= {5'd0, c_mant};
            invalid  <= 1'b0;
            inexact  <= 1'b0;
            unique case (1'b1)
              c_nan: begin
                r       <= NAN_VALUE;
                invalid <= 1'b1;
                state   <= DONE;
              end
              c_inf, is_ovf: begin
                r       <= sat_val;
                invalid <= 1'b1;
                state   <= DONE;
              end
              is_min: begin
                r     <= INT16_MIN;
                state <= DONE;
              end
              c_zero, c_sub: begin
                r       <= 16'd0;
                inexact <= c_sub;
                state   <= DONE;
              end
              default: state <= SHIFT;
            endcase
          end
        end
        SHIFT: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
            if (left_q) begin
              mag_q <= mag_q << 1;
            end else begin
              mag_q    <= mag_q >> 1;
              guard_q  <= mag_q[0];
              sticky_q <= sticky_q | guard_q;
            end
          end
          if (cnt_q <= 4'd1) state <= ROUND;
        end
        ROUND: begin
          r       <= sign_q ? -rnd_mag : rnd_mag;
          inexact <= guard_q | sticky_q;
          invalid <= 1'b0;
          state   <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp16_to_int16_converter.sv
// Bench for fp16_to_int16_converter: vector table, random ops vs a
// value-level model, backpressure and mid-operation reset sequences.
module tb_fp16_to_int16_converter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] r;
  logic        invalid;
  logic        inexact;
  logic        busy;

  always #5 clk = ~clk;

  fp16_to_int16_converter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .invalid   (invalid),
    .inexact   (inexact),
    .busy      (busy)
  );

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp_v);
  endtask

  task automatic timeout_fail(input string nm);
    total++;
    $display("FAIL %s: timed out waiting for out_valid", nm);
  endtask

  typedef struct {
    logic [15:0] x;
    logic [15:0] r;
    logic        inv;
    logic        inx;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [15:0] xv, input logic [15:0] rv,
                              input logic iv, input logic ix, input int l);
    vec_t v;
    v.x = xv; v.r = rv; v.inv = iv; v.inx = ix; v.lat = l;
    vecs.push_back(v);
  endfunction

  // Value-level reference: x = (-1)^s * m * 2^(e-25), then round and clamp
  task automatic model(input logic [15:0] xv, output logic [15:0] rv,
                       output logic iv, output logic ix, output int l);
    logic   s;
    int     e;
    longint f, m, q, rem, half, v;
    int     sh, n;
    s = xv[15];
    e = int'(xv[14:10]);
    f = longint'(xv[9:0]);
    iv = 1'b0; ix = 1'b0; rv = 16'd0;
    if (e >= 30 || e == 0) l = 1;
    else begin
      n = (e >= 25) ? e - 25 : ((25 - e) > 12 ? 12 : 25 - e);
      l = (n < 1 ? 1 : n) + 2;
    end
    if (e == 31) begin
      iv = 1'b1;
      rv = (f != 0) ? 16'h0000 : (s ? 16'h8000 : 16'h7FFF);
    end else if (e == 0) begin
      ix = (f != 0);
    end else begin
      m = 1024 + f;
      rem = 0;
      if (e >= 25) q = m << (e - 25);
      else begin
        sh = 25 - e;
        q = m >> sh;
        rem = m - (q << sh);
        half = longint'(1) << (sh - 1);
`ifdef FP16_CVT_ROUND_EN
        if (rem > half || (rem == half && q[0])) q = q + 1;
`endif
      end
      ix = (rem != 0);
      v = s ? -q : q;
      if (v > 32767 || v < -32768) begin
        iv = 1'b1; ix = 1'b0;
        rv = s ? 16'h8000 : 16'h7FFF;
      end else rv = v[15:0];
    end
  endtask

  task automatic do_op(input logic [15:0] xv, output logic [15:0] rv,
                       output logic iv, output logic ix, output int l);
    bit got;
    got = 0; l = 0; rv = 16'hxxxx; iv = 1'bx; ix = 1'bx;
    @(negedge clk);
    x = xv; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (out_valid) begin
        l = i; rv = r; iv = invalid; ix = inexact; got = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!got) timeout_fail("op_wait");
    @(posedge clk);
    #1;
  endtask

  logic [15:0] ar, er, r0;
  logic        ai, ax, ei, ex, i0, x0;
  int          al, el;
  bit          got;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = 16'h0;

    add(16'h3C00, 16'h0001, 0, 0, 12);
`ifdef FP16_CVT_ROUND_EN
    add(16'h3E00, 16'h0002, 0, 1, 12);
`else
    add(16'h3E00, 16'h0001, 0, 1, 12);
`endif
    add(16'h4100, 16'h0002, 0, 1, 11);
    add(16'hC100, 16'hFFFE, 0, 1, 11);
    add(16'hF800, 16'h8000, 0, 0, 1);
    add(16'h7800, 16'h7FFF, 1, 0, 1);
    add(16'h77FF, 16'h7FF0, 0, 0, 6);
    add(16'h7E00, 16'h0000, 1, 0, 1);
    add(16'hFC00, 16'h8000, 1, 0, 1);
    add(16'h0001, 16'h0000, 0, 1, 1);
    add(16'h3400, 16'h0000, 0, 1, 14);
    add(16'h6400, 16'h0400, 0, 0, 3);
    add(16'h7BFF, 16'h7FFF, 1, 0, 1);
    add(16'hFBFF, 16'h8000, 1, 0, 1);

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_flags", 32'({invalid, inexact}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].x, ar, ai, ax, al);
      chk($sformatf("vec%0d_r", i), 32'(ar), 32'(vecs[i].r));
      chk($sformatf("vec%0d_inv", i), 32'(ai), 32'(vecs[i].inv));
      chk($sformatf("vec%0d_inx", i), 32'(ax), 32'(vecs[i].inx));
      chk($sformatf("vec%0d_lat", i), 32'(al), 32'(vecs[i].lat));
    end

    for (int i = 0; i < 300; i++) begin
      logic [15:0] xv;
      xv = 16'($urandom);
      model(xv, er, ei, ex, el);
      do_op(xv, ar, ai, ax, al);
      chk($sformatf("rnd_%h_r", xv), 32'(ar), 32'(er));
      chk($sformatf("rnd_%h_inv", xv), 32'(ai), 32'(ei));
      chk($sformatf("rnd_%h_inx", xv), 32'(ax), 32'(ex));
      chk($sformatf("rnd_%h_lat", xv), 32'(al), 32'(el));
    end

    // Backpressure: result held in DONE, new operand refused
    model(16'h3E00, er, ei, ex, el);
    @(negedge clk);
    x = 16'h3E00; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) begin got = 1; break; end
      @(posedge clk);
      #1;
    end
    if (!got) timeout_fail("bp_wait");
    r0 = r; i0 = invalid; x0 = inexact;
    chk("bp_r", 32'(r0), 32'(er));
    chk("bp_inx", 32'(x0), 32'(ex));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      x = 16'h3C00; in_valid = 1'b1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("bp_hold", 32'({out_valid, r, invalid, inexact}),
          32'({1'b1, r0, i0, x0}));
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    chk("bp_out_valid_after", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("bp_no_accept", 32'(busy), 32'd0);

    // Reset during SHIFT aborts the operand
    @(negedge clk);
    x = 16'h3C00; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_r", 32'(r), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h4000, ar, ai, ax, al);
    chk("post_rst_r", 32'(ar), 32'd2);
    chk("post_rst_flags", 32'({ai, ax}), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
